// File: rtl/ps2_pkg.sv
// ============================================================================
// Module  : ps2_pkg
// Brief   : Shared types and constants for the PS/2 mouse receiver.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    typedef struct packed {
        logic [8:0] dx;
        logic [8:0] dy;
        logic       btn_left;
        logic       btn_right;
        logic       btn_middle;
        logic       x_ovf;
        logic       y_ovf;
    } ps2_pkt_t;

    localparam int PS2_BTN_L_BIT = 0;
    localparam int PS2_BTN_R_BIT = 1;
    localparam int PS2_BTN_M_BIT = 2;
    localparam int PS2_SYNC_BIT  = 3;
    localparam int PS2_XSIGN_BIT = 4;
    localparam int PS2_YSIGN_BIT = 5;
    localparam int PS2_XOVF_BIT  = 6;
    localparam int PS2_YOVF_BIT  = 7;

    function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned us);
        return (clk_hz / 1_000_000) * us;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_rx_byte.sv
// ============================================================================
// Module  : ps2_rx_byte
// Brief   : PS/2 line synchronizer, falling-edge detect and 11-bit frame FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_rx_byte
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
    parameter int unsigned BIT_TIMEOUT_US = 200,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);

    localparam int unsigned BIT_TO_CYC = us_to_cycles(CLK_FREQ_HZ, BIT_TIMEOUT_US);
    localparam int unsigned BIT_CW     = $clog2(BIT_TO_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;

    ps2_state_t  state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        par_q, par_d;
    logic [BIT_CW-1:0] tmo_q, tmo_d;

    logic w_fall;
    logic w_data;
    logic w_timeout;
    logic w_stop_ok;

    assign w_fall    = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign w_data    = data_sync_q[SYNC_STAGES-1];
    assign w_timeout = (state_q != IDLE) && !w_fall
                       && (tmo_q == BIT_CW'(BIT_TO_CYC - 1));

    // Lines idle high, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (w_timeout) begin
            state_d = IDLE;
        end else if (w_fall) begin
            case (state_q)
                IDLE:    if (!w_data) state_d = DATA;
                DATA:    if (bitcnt_q == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        par_d    = par_q;
        if (w_fall) begin
            case (state_q)
                IDLE:   bitcnt_d = 3'd0;
                DATA: begin
                    shift_d  = {w_data, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                end
                PARITY: par_d = w_data;
                default: ;
            endcase
        end
        // Gap counter restarts on every edge and only runs inside a frame.
        if ((state_q == IDLE) || w_fall || w_timeout) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + BIT_CW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shift_q  <= '0;
            bitcnt_q <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        w_stop_ok    = ((^shift_q) ^ par_q) & w_data;
        byte_valid_o = (state_q == STOP) && w_fall && w_stop_ok;
        frame_err_o  = w_timeout || ((state_q == STOP) && w_fall && !w_stop_ok);
        byte_data_o  = shift_q;
    end

endmodule

`default_nettype wire

// File: rtl/ps2_mouse_rx.sv
// ============================================================================
// Module  : ps2_mouse_rx
// Brief   : Assembles 3-byte PS/2 mouse packets into dx/dy/button outputs.
//           Define PS2_Y_SCREEN_EN to report dy in screen (down-positive) sense.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_mouse_rx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
    parameter int unsigned BIT_TIMEOUT_US = 200,
    parameter int unsigned PKT_TIMEOUT_US = 2000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       packet_valid,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic       btn_left,
    output logic       btn_right,
    output logic       btn_middle,
    output logic       x_ovf,
    output logic       y_ovf,
    output logic       frame_err
);

    localparam int unsigned PKT_TO_CYC = us_to_cycles(CLK_FREQ_HZ, PKT_TIMEOUT_US);
    localparam int unsigned PKT_CW     = $clog2(PKT_TO_CYC + 1);

    logic       w_byte_valid;
    logic [7:0] w_byte;
    logic       w_byte_err;

    ps2_rx_byte #(
        .CLK_FREQ_HZ    (CLK_FREQ_HZ),
        .BIT_TIMEOUT_US (BIT_TIMEOUT_US),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx_byte (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .byte_valid_o (w_byte_valid),
        .byte_data_o  (w_byte),
        .frame_err_o  (w_byte_err)
    );

    // Header byte minus its always-set sync bit: {yovf, xovf, ysign, xsign, m, r, l}.
    logic [1:0]        idx_q, idx_d;
    logic [6:0]        hdr_q, hdr_d;
    logic [7:0]        b1_q, b1_d;
    logic [PKT_CW-1:0] pcnt_q, pcnt_d;
    ps2_pkt_t          pkt_q, pkt_d;
    logic              pv_q, pv_d;
    logic              fe_q, fe_d;

    logic [6:0] w_hdr_new;
    logic [8:0] w_dy_raw;
    logic       w_pkt_tmo;
    ps2_pkt_t   w_pkt_new;

    assign w_hdr_new = {w_byte[PS2_YOVF_BIT], w_byte[PS2_XOVF_BIT],
                        w_byte[PS2_YSIGN_BIT], w_byte[PS2_XSIGN_BIT],
                        w_byte[PS2_BTN_M_BIT], w_byte[PS2_BTN_R_BIT],
                        w_byte[PS2_BTN_L_BIT]};
    assign w_dy_raw  = {hdr_q[4], w_byte};
    assign w_pkt_tmo = (idx_q != 2'd0) && !w_byte_valid && !w_byte_err
                       && (pcnt_q == PKT_CW'(PKT_TO_CYC - 1));

    always_comb begin
        w_pkt_new.dx         = {hdr_q[3], b1_q};
`ifdef PS2_Y_SCREEN_EN
        // -(-256) does not fit in 9 bits, so it clamps to the largest positive value.
        w_pkt_new.dy         = (w_dy_raw == 9'h100) ? 9'h0FF : (9'd0 - w_dy_raw);
`else
        w_pkt_new.dy         = w_dy_raw;
`endif
        w_pkt_new.btn_left   = hdr_q[0];
        w_pkt_new.btn_right  = hdr_q[1];
        w_pkt_new.btn_middle = hdr_q[2];
        w_pkt_new.x_ovf      = hdr_q[5];
        w_pkt_new.y_ovf      = hdr_q[6];
    end

    always_comb begin
        idx_d = idx_q;
        hdr_d = hdr_q;
        b1_d  = b1_q;
        pkt_d = pkt_q;
        pv_d  = 1'b0;
        fe_d  = w_byte_err;
        if (w_byte_err) begin
            idx_d = 2'd0;
        end else if (w_byte_valid) begin
            case (idx_q)
                2'd0: begin
                    // A header without the sync bit is dropped so the stream can realign.
                    if (w_byte[PS2_SYNC_BIT]) begin
                        hdr_d = w_hdr_new;
                        idx_d = 2'd1;
                    end
                end
                2'd1: begin
                    b1_d  = w_byte;
                    idx_d = 2'd2;
                end
                default: begin
                    idx_d = 2'd0;
                    pv_d  = 1'b1;
                    pkt_d = w_pkt_new;
                end
            endcase
        end else if (w_pkt_tmo) begin
            idx_d = 2'd0;
        end

        if ((idx_q == 2'd0) || w_byte_valid || w_byte_err || w_pkt_tmo) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PKT_CW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx_q  <= 2'd0;
            hdr_q  <= '0;
            b1_q   <= '0;
            pcnt_q <= '0;
            pkt_q  <= '0;
            pv_q   <= 1'b0;
            fe_q   <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            hdr_q  <= hdr_d;
            b1_q   <= b1_d;
            pcnt_q <= pcnt_d;
            pkt_q  <= pkt_d;
            pv_q   <= pv_d;
            fe_q   <= fe_d;
        end
    end

    assign packet_valid = pv_q;
    assign frame_err    = fe_q;
    assign dx           = pkt_q.dx;
    assign dy           = pkt_q.dy;
    assign btn_left     = pkt_q.btn_left;
    assign btn_right    = pkt_q.btn_right;
    assign btn_middle   = pkt_q.btn_middle;
    assign x_ovf        = pkt_q.x_ovf;
    assign y_ovf        = pkt_q.y_ovf;

endmodule

`default_nettype wire

// File: tb/tb_ps2_mouse_rx.sv
// ============================================================================
// Module  : tb_ps2_mouse_rx
// Brief   : Directed bench for ps2_mouse_rx; one clock cycle stands for 1 us.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_mouse_rx;

    localparam int HALF = 40;

    logic       clk_in   = 1'b0;
    logic       rst_in   = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       packet_valid;
    logic [8:0] dx;
    logic [8:0] dy;
    logic       btn_left;
    logic       btn_right;
    logic       btn_middle;
    logic       x_ovf;
    logic       y_ovf;
    logic       frame_err;

    int n_total  = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int pv_cnt   = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;
    int pv_cyc   = 0;
    int fe_cyc   = 0;
    int fall_cyc = 0;
    int pv0;
    int fe0;
    int d;

    ps2_mouse_rx #(
        .CLK_FREQ_HZ    (1_000_000),
        .BIT_TIMEOUT_US (200),
        .PKT_TIMEOUT_US (2000),
        .SYNC_STAGES    (2)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .packet_valid (packet_valid),
        .dx           (dx),
        .dy           (dy),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_middle   (btn_middle),
        .x_ovf        (x_ovf),
        .y_ovf        (y_ovf),
        .frame_err    (frame_err)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (packet_valid) begin
            pv_cnt = pv_cnt + 1;
            pv_cyc = cyc;
        end
        if (frame_err) begin
            fe_cnt = fe_cnt + 1;
            fe_cyc = cyc;
        end
        if (packet_valid && frame_err) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ey(input logic [8:0] up, input logic [8:0] scr);
`ifdef PS2_Y_SCREEN_EN
        return scr;
`else
        return up;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        tick(HALF);
        ps2_clk  = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(stop);
        ps2_data = 1'b1;
        tick(100);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b0, 1'b1);
        send_byte(b1, 1'b0, 1'b1);
        send_byte(b2, 1'b0, 1'b1);
    endtask

    task automatic chk_fields(input string tag, input logic [8:0] edx, input logic [8:0] edy,
                              input logic [2:0] ebtn, input logic [1:0] eovf);
        chk({tag, "_dx"},  32'(dx), 32'(edx));
        chk({tag, "_dy"},  32'(dy), 32'(edy));
        chk({tag, "_btn"}, 32'({btn_middle, btn_right, btn_left}), 32'(ebtn));
        chk({tag, "_ovf"}, 32'({y_ovf, x_ovf}), 32'(eovf));
    endtask

    initial begin
        tick(3);
        chk("rst_fields", 32'({packet_valid, frame_err, dx, dy, btn_left, btn_right,
                               btn_middle, x_ovf, y_ovf}), 32'd0);
        rst_in = 1'b0;
        tick(5);

        // Header 0x18 carries the X sign bit, so dx = {1,0x05}.
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_pkt(8'h18, 8'h05, 8'hFB);
        chk("p1_pv", pv_cnt - pv0, 1);
        chk("p1_fe", fe_cnt - fe0, 0);
        chk("p1_lat", pv_cyc - fall_cyc, 3);
        chk_fields("p1", 9'h105, ey(9'h0FB, 9'h105), 3'b000, 2'b00);

        pv0 = pv_cnt;
        send_pkt(8'h28, 8'h05, 8'hFB);
        chk("p2_pv", pv_cnt - pv0, 1);
        chk_fields("p2", 9'h005, ey(9'h1FB, 9'h005), 3'b000, 2'b00);

        pv0 = pv_cnt; fe0 = fe_cnt;
        send_byte(8'h09, 1'b1, 1'b1);
        chk("par_fe", fe_cnt - fe0, 1);
        chk("par_pv", pv_cnt - pv0, 0);
        send_pkt(8'h09, 8'h00, 8'h00);
        chk("par_next_pv", pv_cnt - pv0, 1);
        chk_fields("par_next", 9'h000, 9'h000, 3'b001, 2'b00);

        pv0 = pv_cnt; fe0 = fe_cnt;
        send_byte(8'h08, 1'b0, 1'b0);
        chk("stop_fe", fe_cnt - fe0, 1);
        chk("stop_pv", pv_cnt - pv0, 0);

        fe0 = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        ps2_data = 1'b1;
        tick(300);
        chk("tmo_fe", fe_cnt - fe0, 1);
        d = fe_cyc - fall_cyc;
        chk("tmo_lat", 32'(d >= 201 && d <= 205), 1);
        pv0 = pv_cnt;
        send_pkt(8'h0A, 8'h7F, 8'h80);
        chk("tmo_next_pv", pv_cnt - pv0, 1);
        chk_fields("tmo_next", 9'h07F, ey(9'h080, 9'h180), 3'b010, 2'b00);

        pv0 = pv_cnt; fe0 = fe_cnt;
        send_byte(8'h00, 1'b0, 1'b1);
        send_pkt(8'h18, 8'h01, 8'h02);
        chk("sync_pv", pv_cnt - pv0, 1);
        chk("sync_fe", fe_cnt - fe0, 0);
        chk_fields("sync", 9'h101, ey(9'h002, 9'h1FE), 3'b000, 2'b00);

        pv0 = pv_cnt;
        send_byte(8'h0C, 1'b0, 1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        rst_in = 1'b1;
        tick(1);
        rst_in = 1'b0;
        chk("mrst_fields", 32'({packet_valid, frame_err, dx, dy, btn_left, btn_right,
                                btn_middle, x_ovf, y_ovf}), 32'd0);
        ps2_data = 1'b1;
        tick(100);
        send_pkt(8'h08, 8'h11, 8'h22);
        chk("mrst_pv", pv_cnt - pv0, 1);
        chk_fields("mrst", 9'h011, ey(9'h022, 9'h1DE), 3'b000, 2'b00);

        send_pkt(8'hC8, 8'h00, 8'h00);
        chk_fields("ovf", 9'h000, 9'h000, 3'b000, 2'b11);

        send_pkt(8'h28, 8'h00, 8'h00);
        chk_fields("ymin", 9'h000, ey(9'h100, 9'h0FF), 3'b000, 2'b00);
        send_pkt(8'h08, 8'h00, 8'h03);
        chk_fields("y3", 9'h000, ey(9'h003, 9'h1FD), 3'b000, 2'b00);

        pv0 = pv_cnt; fe0 = fe_cnt;
        send_byte(8'h08, 1'b0, 1'b1);
        send_byte(8'h01, 1'b0, 1'b1);
        tick(2500);
        send_pkt(8'h08, 8'h03, 8'h04);
        chk("ptmo_pv", pv_cnt - pv0, 1);
        chk("ptmo_fe", fe_cnt - fe0, 0);
        chk_fields("ptmo", 9'h003, ey(9'h004, 9'h1FC), 3'b000, 2'b00);

        chk("pv_fe_overlap", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
